mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single DPI-backed memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time, arbitrates round-robin on contention, and sequences the request/response handshake with the memory port.
- Routes each response back to its owner.
- Bounds every transaction with a watchdog timeout, so a missing memory response returns an error instead of hanging the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte-mask width is DATA_W/8
TIMEOUT, 255, cycles allowed in ISSUE+WAIT before forced error response; 0 disables the watchdog

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  one-cycle response pulse to IFU
ifu_rdata  out  DATA_W  fetched word
ifu_resp_err  out  1  timeout error, qualified by ifu_resp_valid
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  one-cycle response pulse to LSU
lsu_rdata  out  DATA_W  load data; 0 for stores
lsu_resp_err  out  1  timeout error, qualified by lsu_resp_valid
mem_req_valid  out  1  request to memory port
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_W  latched write data
mem_wmask  out  DATA_W/8  latched byte mask
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding.
- IDLE: req_ready is combinational and asserted only for the granted requester, and only in IDLE.
  - One valid requester: it is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - On accept (valid & ready), latch at the clock edge: addr, wen, wdata, wmask, owner. Set last_grant = owner, clear the timeout counter, go to ISSUE.
  - IFU requests latch wen = 0, wmask = 0, wdata = 0.
- ISSUE: mem_req_valid = 1. mem_addr, mem_wen, mem_wdata and mem_wmask are driven from latches and stay stable until mem_req_ready. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, capture mem_rdata, or 0 if wen. Set err = 0, go to RESP.
  - mem_resp_valid in the same cycle as the ISSUE handshake is not expected. It is ignored.
- Timeout: the counter increments each cycle in ISSUE or WAIT. When it reaches TIMEOUT (TIMEOUT != 0), go to RESP with err = 1 and rdata = 0, and deassert mem_req_valid. A late mem_resp_valid in any state other than WAIT is ignored.
- RESP: for exactly one cycle, assert the owner's resp_valid with its rdata and resp_err. The other requester's resp outputs are 0. Next state is IDLE.
- Latency: accept at edge N. mem_req_valid is high during cycle N+1. With immediate ready and a response in the first WAIT cycle, resp_valid is high in cycle N+3. The next accept can occur in cycle N+4.
- A requester may drop valid before it is accepted; no grant is committed. Inputs are ignored outside IDLE.
- Reset, asserted asynchronously at any time:
  - state = IDLE, last_grant = IFU (so the LSU wins the first contention), counter = 0, latches = 0.
  - All outputs = 0.
  - An in-flight transaction is aborted with no response.

Test Plan:
- IFU only, addr 0x8000_0000, mem ready immediately, response next cycle with 0x0010_0073 -> mem_addr = 0x8000_0000, mem_wen = 0; ifu_resp_valid one cycle at N+3 with ifu_rdata = 0x0010_0073, err = 0; lsu_resp_valid stays 0.
- Both valid from reset, LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, mask 0xF -> LSU granted first (mem_wen = 1, mem_wmask = 0xF, lsu_rdata = 0). IFU is granted next. Under sustained contention, grants alternate LSU, IFU, LSU, IFU.
- mem_req_ready held low 3 cycles -> mem_req_valid high and addr/wdata/wmask stable for all 4 cycles; response routed correctly afterwards.
- TIMEOUT = 8, memory never responds -> resp_valid with err = 1, rdata = 0 exactly 8 cycles after entering ISSUE. A mem_resp_valid pulse arriving afterwards produces no response. The next request is served normally.
- rst asserted during WAIT -> outputs 0 immediately (asynchronous), no resp_valid. After release, IFU/LSU contention grants LSU first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One outstanding transaction, round-robin on contention, watchdog-bounded.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TMO_LIM = (CNT_W + 1)'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]        state;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt_q;

    logic              owner_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              wen_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [MASK_W-1:0] wmask_p0;

    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;

    logic              gnt_ifu;
    logic              gnt_lsu;
    logic [CNT_W:0]    cnt_inc;
    logic              tmo_hit;

    // Grant only from IDLE; on contention the requester that did not win last time goes first.
    always_comb begin
        gnt_lsu = 1'b0;
        gnt_ifu = 1'b0;
        if (state == S_IDLE && !rst) begin
            gnt_lsu = lsu_req_valid && (!ifu_req_valid || last_grant == OWN_IFU);
            gnt_ifu = ifu_req_valid && (!lsu_req_valid || last_grant == OWN_LSU);
        end
    end

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        tmo_hit = (TIMEOUT != 0) && (cnt_inc == TMO_LIM);
    end

    assign ifu_req_ready  = gnt_ifu;
    assign lsu_req_ready  = gnt_lsu;

    assign mem_req_valid  = (state == S_ISSUE);
    assign mem_addr       = addr_p0;
    assign mem_wen        = wen_p0;
    assign mem_wdata      = wdata_p0;
    assign mem_wmask      = wmask_p0;

    assign ifu_resp_valid = (state == S_RESP) && (owner_p0 == OWN_IFU);
    assign lsu_resp_valid = (state == S_RESP) && (owner_p0 == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? rdata_p1 : '0;
    assign lsu_rdata      = lsu_resp_valid ? rdata_p1 : '0;
    assign ifu_resp_err   = ifu_resp_valid & err_p1;
    assign lsu_resp_err   = lsu_resp_valid & err_p1;

    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= OWN_IFU;
            cnt_q      <= '0;
            owner_p0   <= OWN_IFU;
            addr_p0    <= '0;
            wen_p0     <= 1'b0;
            wdata_p0   <= '0;
            wmask_p0   <= '0;
            rdata_p1   <= '0;
            err_p1     <= 1'b0;
        end else begin
            case (state)
                // Request capture stage
                S_IDLE: begin
                    if (gnt_lsu) begin
                        owner_p0   <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        addr_p0    <= lsu_addr;
                        wen_p0     <= lsu_wen;
                        wdata_p0   <= lsu_wdata;
                        wmask_p0   <= lsu_wmask;
                        cnt_q      <= '0;
                        state      <= S_ISSUE;
                    end else if (gnt_ifu) begin
                        owner_p0   <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        addr_p0    <= ifu_addr;
                        wen_p0     <= 1'b0;
                        wdata_p0   <= '0;
                        wmask_p0   <= '0;
                        cnt_q      <= '0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (TIMEOUT != 0) cnt_q <= cnt_inc[CNT_W-1:0];
                    if (tmo_hit) begin
                        rdata_p1 <= '0;
                        err_p1   <= 1'b1;
                        state    <= S_RESP;
                    end else if (mem_req_ready) begin
                        state    <= S_WAIT;
                    end
                end
                // Response capture stage; a real response beats a coincident timeout
                S_WAIT: begin
                    if (TIMEOUT != 0) cnt_q <= cnt_inc[CNT_W-1:0];
                    if (mem_resp_valid) begin
                        rdata_p1 <= wen_p0 ? '0 : mem_rdata;
                        err_p1   <= 1'b0;
                        state    <= S_RESP;
                    end else if (tmo_hit) begin
                        rdata_p1 <= '0;
                        err_p1   <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a behavioural model predicts grants,
// memory-side requests and routed responses; monitors compare on every falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behaviour: 0 fixed delays, 1 random delays, 2 silent, 3 responds far too late
    int mem_mode = 0;
    int rdy_dly  = 0;
    int rsp_dly  = 0;
    bit done     = 1'b0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return (a ^ 32'h5A5A_0F0F) + 32'h0000_1357;
    endfunction

    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } txn_t;

    txn_t q[$];
    txn_t mq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: grant model, memory-side and response-side checks
    initial begin
        txn_t e;
        logic m_busy, m_last, idle_next, exp_i, exp_l;
        m_busy = 0; m_last = 0; idle_next = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctrl_outs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                                      ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen, busy}, 32'h0);
                chk("rst_data_outs", ifu_rdata | lsu_rdata | mem_addr | mem_wdata | {28'h0, mem_wmask}, 32'h0);
                q.delete(); mq.delete();
                m_busy = 0; m_last = 0; idle_next = 0;
                continue;
            end
            if (done) begin
                chk("resp_queue_drained", 32'(q.size()), 32'h0);
                chk("mem_queue_drained", 32'(mq.size()), 32'h0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (idle_next) begin m_busy = 0; idle_next = 0; end
            chk("busy", {31'h0, busy}, {31'h0, m_busy});

            if (ifu_resp_valid || lsu_resp_valid) begin
                idle_next = 1;
                chk("resp_onehot", {31'h0, ifu_resp_valid & lsu_resp_valid}, 32'h0);
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL resp_unexpected: ifu_resp_valid=%0b lsu_resp_valid=%0b, required no response (cycle %0d)",
                             ifu_resp_valid, lsu_resp_valid, cyc);
                end else begin
                    e = q.pop_front();
                    chk("resp_owner_lsu", {31'h0, lsu_resp_valid}, {31'h0, e.own});
                    chk("resp_rdata", e.own ? lsu_rdata : ifu_rdata, e.rdata);
                    chk("resp_err", {31'h0, e.own ? lsu_resp_err : ifu_resp_err}, {31'h0, e.err});
                    chk("other_resp_quiet", e.own ? (ifu_rdata | {31'h0, ifu_resp_err})
                                                  : (lsu_rdata | {31'h0, lsu_resp_err}), 32'h0);
                    if (e.lat >= 0) chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end

            if (mem_req_valid) begin
                if (mq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_req_unexpected: mem_req_valid=1 addr=%h, required no request (cycle %0d)", mem_addr, cyc);
                end else begin
                    chk("mem_addr", mem_addr, mq[0].addr);
                    chk("mem_wen", {31'h0, mem_wen}, {31'h0, mq[0].wen});
                    chk("mem_wdata", mem_wdata, mq[0].wdata);
                    chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, mq[0].wmask});
                    if (mem_req_ready) void'(mq.pop_front());
                end
            end

            exp_l = !m_busy && lsu_req_valid && (!ifu_req_valid || m_last == 1'b0);
            exp_i = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last == 1'b1);
            chk("ifu_req_ready", {31'h0, ifu_req_ready}, {31'h0, exp_i});
            chk("lsu_req_ready", {31'h0, lsu_req_ready}, {31'h0, exp_l});
            if (exp_i || exp_l) begin
                e.own   = exp_l;
                e.addr  = exp_l ? lsu_addr : ifu_addr;
                e.wen   = exp_l ? lsu_wen : 1'b0;
                e.wdata = exp_l ? lsu_wdata : 32'h0;
                e.wmask = exp_l ? lsu_wmask : 4'h0;
                e.err   = (mem_mode == 2 || mem_mode == 3);
                e.rdata = (e.err || e.wen) ? 32'h0 : rd_fn(e.addr);
                e.lat   = (mem_mode == 0) ? 3 + rdy_dly + rsp_dly : (mem_mode == 3) ? 9 : -1;
                e.acc   = cyc;
                q.push_back(e);
                mq.push_back(e);
                m_busy = 1;
                m_last = exp_l;
            end
        end
    end

    // Memory port responder
    initial begin
        logic [31:0] a;
        logic        w;
        int          d, r;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst || !mem_req_valid) continue;
            d = (mem_mode == 1) ? int'($urandom_range(0, 2)) : rdy_dly;
            r = (mem_mode == 1) ? int'($urandom_range(0, 2)) : rsp_dly;
            repeat (d) begin @(posedge clk); #1; end
            a = mem_addr; w = mem_wen;
            mem_req_ready = 1;
            @(posedge clk); #1 mem_req_ready = 0;
            if (mem_mode == 2) continue;
            if (mem_mode == 3) r = 12;
            repeat (r) begin @(posedge clk); #1; end
            mem_resp_valid = 1;
            mem_rdata = w ? 32'hBAD0_5709 : rd_fn(a);
            @(posedge clk); #1 mem_resp_valid = 0;
            mem_rdata = $urandom();
        end
    end

    task automatic drive_ifu(input int n, input bit rnd, input logic [31:0] base);
        int guard;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            ifu_addr = rnd ? ($urandom() & 32'hFFFF_FFFC) : base + 32'(i * 4);
            ifu_req_valid = 1;
            forever begin
                @(negedge clk);
                if (ifu_req_ready) break;
                guard++;
                if (guard > 300) begin
                    $display("FAIL ifu_grant_timeout: no grant after %0d cycles, required a grant", guard);
                    $fatal(1, "ifu request never granted");
                end
                if (rnd && $urandom_range(0, 7) == 0) begin
                    @(posedge clk); #1 ifu_req_valid = 0;
                    ifu_addr = $urandom() & 32'hFFFF_FFFC;
                end
                @(posedge clk); #1 ifu_req_valid = 1;
            end
            @(posedge clk); #1 ifu_req_valid = 0;
        end
    endtask

    task automatic drive_lsu(input int n, input bit rnd, input logic [31:0] base, input logic wen,
                             input logic [31:0] wdata, input logic [3:0] mask);
        int guard;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            lsu_addr  = rnd ? ($urandom() & 32'hFFFF_FFFC) : base + 32'(i * 4);
            lsu_wen   = rnd ? 1'($urandom_range(0, 1)) : wen;
            lsu_wdata = rnd ? $urandom() : wdata;
            lsu_wmask = rnd ? 4'($urandom_range(0, 15)) : mask;
            lsu_req_valid = 1;
            forever begin
                @(negedge clk);
                if (lsu_req_ready) break;
                guard++;
                if (guard > 300) begin
                    $display("FAIL lsu_grant_timeout: no grant after %0d cycles, required a grant", guard);
                    $fatal(1, "lsu request never granted");
                end
                if (rnd && $urandom_range(0, 7) == 0) begin
                    @(posedge clk); #1 lsu_req_valid = 0;
                    lsu_wdata = $urandom();
                end
                @(posedge clk); #1 lsu_req_valid = 1;
            end
            @(posedge clk); #1 lsu_req_valid = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1;
        ifu_req_valid = 0; ifu_addr = 32'h0;
        lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wen = 0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        repeat (3) @(posedge clk);
        #3 rst = 0;

        // Sustained contention straight out of reset: LSU, IFU, LSU, IFU ...
        fork
            drive_ifu(4, 0, 32'h8000_0200);
            drive_lsu(4, 0, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF);
        join
        repeat (10) @(posedge clk);

        // Single fetch, immediate memory
        drive_ifu(1, 0, 32'h8000_0000);
        repeat (10) @(posedge clk);

        // Memory holds off ready for three cycles
        rdy_dly = 3; rsp_dly = 1;
        drive_lsu(1, 0, 32'h8000_0040, 1'b0, 32'h1234_5678, 4'h3);
        repeat (15) @(posedge clk);
        rdy_dly = 0; rsp_dly = 0;

        // Watchdog expiry, then a stray late response, then a normal request
        mem_mode = 3;
        drive_ifu(1, 0, 32'h8000_0080);
        repeat (25) @(posedge clk);
        mem_mode = 0;
        drive_ifu(1, 0, 32'h8000_0084);
        repeat (10) @(posedge clk);

        // Randomized traffic
        mem_mode = 1;
        fork
            drive_ifu(150, 1, 32'h0);
            drive_lsu(150, 1, 32'h0, 1'b0, 32'h0, 4'h0);
        join
        repeat (20) @(posedge clk);

        // Asynchronous reset in the middle of WAIT
        mem_mode = 2;
        drive_ifu(1, 0, 32'h8000_00C0);
        repeat (3) @(posedge clk);
        #2 rst = 1;
        ifu_req_valid = 1; lsu_req_valid = 1;
        @(posedge clk);
        @(posedge clk); #1;
        ifu_req_valid = 0; lsu_req_valid = 0;
        #2 rst = 0;
        mem_mode = 0;
        fork
            drive_ifu(1, 0, 32'h8000_0300);
            drive_lsu(1, 0, 32'h8000_0400, 1'b0, 32'h0, 4'h0);
        join
        repeat (15) @(posedge clk);
        #1 done = 1;
    end

endmodule
